// File: rtl/unid_controle_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, ALU ops,
// opcode/funct values and the ALU/PC operand-select codes.
package unid_controle_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Must stay identical to the ALU's own OP table.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_itype(input logic [5:0] opc);
    return (opc == OPC_ADDI) || (opc == OPC_SLTI) || (opc == OPC_SLTIU) ||
           (opc == OPC_ANDI) || (opc == OPC_ORI)  || (opc == OPC_XORI)  ||
           (opc == OPC_LUI);
  endfunction

endpackage

// File: rtl/unid_controle_mc_ula_op_dec.sv
// R-type funct -> ALU OP decoder; purely combinational, valid=0 for unknown funct.
module ula_op_dec
  import unid_controle_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] op,
  output logic       valid
);

  always_comb begin
    op    = ALU_ADD;
    valid = 1'b1;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_XOR:  op = ALU_XOR;
      FN_NOR:  op = ALU_NOR;
      FN_SLT:  op = ALU_SLT;
      FN_SLTU: op = ALU_SLTU;
      FN_SLLV: op = ALU_SLL;
      FN_SRLV: op = ALU_SRL;
      FN_SRAV: op = ALU_SRA;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/unid_controle_mc.sv
// Multi-cycle MIPS control FSM (FETCH..WRITEBACK) driving ALU OP, operand selects and strobes.
// CTRL_ILLEGAL_TRAP_EN: illegal instructions park in TRAP; otherwise they retire as a NOP.
module unid_controle_mc
  import unid_controle_mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero_flag,
  input  logic       mem_ready,
  output logic [3:0] OP,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state_dbg
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  localparam state_t ILL_NXT = TRAP_EN ? S_TRAP : S_FETCH;

  state_t     state, nxt;
  logic [3:0] fn_op;
  logic       fn_vld;

  ula_op_dec u_ula_op_dec (
    .funct (funct),
    .op    (fn_op),
    .valid (fn_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= state_t'(RESET_STATE);
    else     state <= nxt;
  end

  assign state_dbg = state;

  // Outputs are gated by rst so nothing is issued while reset is held.
  always_comb begin
    nxt        = state;
    OP         = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    imm_zext   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          pc_src    = PCSRC_ALU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) nxt = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = SRCB_BR;
          if (opcode == OPC_RTYPE)                         nxt = S_EXEC_R;
          else if (is_itype(opcode))                       nxt = S_EXEC_I;
          else if (opcode == OPC_LW || opcode == OPC_SW)   nxt = S_MEM_ADDR;
          else if (opcode == OPC_BEQ || opcode == OPC_BNE) nxt = S_BRANCH;
          else if (opcode == OPC_J)                        nxt = S_JUMP;
          else begin
            illegal = ~TRAP_EN;
            nxt     = ILL_NXT;
          end
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REG;
          OP        = fn_op;
          if (fn_vld) nxt = S_WB_R;
          else begin
            illegal = ~TRAP_EN;
            nxt     = ILL_NXT;
          end
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          case (opcode)
            OPC_SLTI:  OP = ALU_SLT;
            OPC_SLTIU: OP = ALU_SLTU;
            OPC_ANDI:  OP = ALU_AND;
            OPC_ORI:   OP = ALU_OR;
            OPC_XORI:  OP = ALU_XOR;
            OPC_LUI:   OP = ALU_LUI;
            default:   OP = ALU_ADD;
          endcase
          imm_zext = (opcode == OPC_ANDI) || (opcode == OPC_ORI) || (opcode == OPC_XORI);
          nxt      = S_WB_I;
        end
        S_WB_R: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          nxt       = S_FETCH;
        end
        S_WB_I: begin
          reg_write = 1'b1;
          nxt       = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          nxt       = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) nxt = S_WB_MEM;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          nxt        = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) nxt = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REG;
          OP        = ALU_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_write  = ((opcode == OPC_BEQ) &&  Zero_flag) ||
                      ((opcode == OPC_BNE) && !Zero_flag);
          nxt       = S_FETCH;
        end
        S_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
          nxt      = S_FETCH;
        end
        S_TRAP: begin
          illegal = TRAP_EN;
          nxt     = ILL_NXT;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_unid_controle_mc.sv
// Directed bench for unid_controle_mc: state sequences and decoded outputs per instruction class.
module tb_unid_controle_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       Zero_flag, mem_ready;
  logic [3:0] OP;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext, pc_write;
  logic [1:0] pc_src;
  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unid_controle_mc dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .Zero_flag(Zero_flag), .mem_ready(mem_ready),
    .OP(OP), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
    .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then check the current state.
  task automatic cyc(input string tag, input logic [3:0] s);
    #1;
    check_eq(tag, 32'(state_dbg), 32'(s));
  endtask

  // Walk FETCH and DECODE with mem_ready=1.
  task automatic fetch_decode(input string tag);
    mem_ready = 1'b1;
    cyc({tag, "_fetch"}, 4'd0);
    tick();
    cyc({tag, "_decode"}, 4'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] lw_st [8];
    logic       lw_rdy [8];
    logic [5:0] br_op [4];
    logic       br_z [4];
    logic       br_pw [4];

    lw_st  = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd9};
    lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    br_op  = '{6'h04, 6'h04, 6'h05, 6'h05};
    br_z   = '{1'b1, 1'b0, 1'b0, 1'b1};
    br_pw  = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; opcode = 6'h00; funct = 6'h20; Zero_flag = 1'b0; mem_ready = 1'b1;
    #2;
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_pc_write", 32'(pc_write), 32'd0);
    check_eq("rst_ir_write", 32'(ir_write), 32'd0);
    check_eq("rst_src_b", 32'(alu_src_b), 32'd0);
    check_eq("rst_op", 32'(OP), 32'd0);
    tick();
    rst = 1'b0;

    // add
    opcode = 6'h00; funct = 6'h20;
    cyc("add_fetch", 4'd0);
    check_eq("add_fetch_ir_write", 32'(ir_write), 32'd1);
    check_eq("add_fetch_pc_write", 32'(pc_write), 32'd1);
    check_eq("add_fetch_mem_read", 32'(mem_read), 32'd1);
    check_eq("add_fetch_src_b", 32'(alu_src_b), 32'd1);
    check_eq("add_fetch_reg_write", 32'(reg_write), 32'd0);
    tick();
    cyc("add_decode", 4'd1);
    check_eq("add_decode_src_b", 32'(alu_src_b), 32'd3);
    check_eq("add_decode_reg_write", 32'(reg_write), 32'd0);
    tick();
    cyc("add_exec", 4'd2);
    check_eq("add_exec_op", 32'(OP), 32'd0);
    check_eq("add_exec_src_a", 32'(alu_src_a), 32'd1);
    check_eq("add_exec_reg_write", 32'(reg_write), 32'd0);
    tick();
    cyc("add_wb", 4'd7);
    check_eq("add_wb_reg_write", 32'(reg_write), 32'd1);
    check_eq("add_wb_reg_dst", 32'(reg_dst), 32'd1);
    tick();

    // lw with three stall cycles: 8 cycles in total
    opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      mem_ready = lw_rdy[i];
      cyc($sformatf("lw_state%0d", i), lw_st[i]);
      if (i == 3) begin
        check_eq("lw_rd_mem_read", 32'(mem_read), 32'd1);
        check_eq("lw_rd_iord", 32'(iord), 32'd1);
        check_eq("lw_rd_reg_write", 32'(reg_write), 32'd0);
      end
      if (i == 7) begin
        check_eq("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        check_eq("lw_wb_reg_write", 32'(reg_write), 32'd1);
        check_eq("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
      end
      tick();
    end
    mem_ready = 1'b1;

    // beq / bne with both Zero_flag values
    for (int i = 0; i < 4; i++) begin
      opcode = br_op[i]; Zero_flag = br_z[i];
      fetch_decode($sformatf("br%0d", i));
      cyc($sformatf("br%0d_branch", i), 4'd10);
      check_eq($sformatf("br%0d_pc_write", i), 32'(pc_write), 32'(br_pw[i]));
      check_eq($sformatf("br%0d_pc_src", i), 32'(pc_src), 32'd1);
      check_eq($sformatf("br%0d_op", i), 32'(OP), 32'd1);
      tick();
    end
    Zero_flag = 1'b0;

    // srav
    opcode = 6'h00; funct = 6'h07;
    fetch_decode("srav");
    cyc("srav_exec", 4'd2);
    check_eq("srav_op", 32'(OP), 32'd10);
    check_eq("srav_src_a", 32'(alu_src_a), 32'd1);
    check_eq("srav_src_b", 32'(alu_src_b), 32'd0);
    tick();
    cyc("srav_wb", 4'd7);
    tick();

    // andi
    opcode = 6'h0C;
    fetch_decode("andi");
    cyc("andi_exec", 4'd3);
    check_eq("andi_op", 32'(OP), 32'd2);
    check_eq("andi_zext", 32'(imm_zext), 32'd1);
    check_eq("andi_src_b", 32'(alu_src_b), 32'd2);
    tick();
    cyc("andi_wb", 4'd8);
    check_eq("andi_wb_reg_write", 32'(reg_write), 32'd1);
    check_eq("andi_wb_reg_dst", 32'(reg_dst), 32'd0);
    tick();

    // lui: sign-extend path, LUI op
    opcode = 6'h0F;
    fetch_decode("lui");
    cyc("lui_exec", 4'd3);
    check_eq("lui_op", 32'(OP), 32'd11);
    check_eq("lui_zext", 32'(imm_zext), 32'd0);
    tick();
    cyc("lui_wb", 4'd8);
    tick();

    // j
    opcode = 6'h02;
    fetch_decode("j");
    cyc("j_jump", 4'd11);
    check_eq("j_pc_write", 32'(pc_write), 32'd1);
    check_eq("j_pc_src", 32'(pc_src), 32'd2);
    tick();

    // illegal opcode 3F
    opcode = 6'h3F;
`ifdef CTRL_ILLEGAL_TRAP_EN
    fetch_decode("ill");
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("trap%0d_state", i), 4'd12);
      check_eq($sformatf("trap%0d_illegal", i), 32'(illegal), 32'd1);
      check_eq($sformatf("trap%0d_strobes", i),
               32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
      tick();
    end
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    mem_ready = 1'b1;
    cyc("ill_fetch", 4'd0);
    tick();
    cyc("ill_decode", 4'd1);
    check_eq("ill_decode_illegal", 32'(illegal), 32'd1);
    check_eq("ill_decode_reg_write", 32'(reg_write), 32'd0);
    tick();
    cyc("ill_back_fetch", 4'd0);
    check_eq("ill_after_illegal", 32'(illegal), 32'd0);
    tick();
    // unknown funct retires as a NOP from EXEC_R
    opcode = 6'h00; funct = 6'h3F;
    cyc("badfn_decode", 4'd1);
    tick();
    cyc("badfn_exec", 4'd2);
    check_eq("badfn_illegal", 32'(illegal), 32'd1);
    check_eq("badfn_reg_write", 32'(reg_write), 32'd0);
    tick();
    cyc("badfn_back_fetch", 4'd0);
    check_eq("badfn_after_illegal", 32'(illegal), 32'd0);
    tick();
    cyc("badfn_refetch_decode", 4'd1);
    tick();
    cyc("badfn_refetch_exec", 4'd2);
    tick();
    cyc("badfn_refetch_fetch", 4'd0);
    tick();
    tick();
    tick();
`endif

    // sw: reset raised during a MEM_WR stall
    opcode = 6'h2B; funct = 6'h20;
    fetch_decode("sw");
    cyc("sw_addr", 4'd4);
    tick();
    mem_ready = 1'b0;
    cyc("sw_wr0", 4'd6);
    check_eq("sw_wr0_mem_write", 32'(mem_write), 32'd1);
    check_eq("sw_wr0_iord", 32'(iord), 32'd1);
    tick();
    cyc("sw_wr1", 4'd6);
    check_eq("sw_wr1_mem_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("sw_rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("sw_rst_state", 32'(state_dbg), 32'd0);
    check_eq("sw_rst_reg_write", 32'(reg_write), 32'd0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    cyc("resume_fetch", 4'd0);
    check_eq("resume_ir_write", 32'(ir_write), 32'd1);
    tick();
    cyc("resume_decode", 4'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
